// File: rtl/iob_timer_countdown_if.sv
// -----------------------------------------------------------------------------
// iob_timer_countdown_if
//
// Purpose:
//   Groups the control and status signals of the down-counting alarm timer into
//   one bundle. The CSR side drives the controls through the master modport.
//   The timer core receives them through the slave modport.
//
// Optional feature:
//   IOB_TIMER_COUNTDOWN_PRESCALE_EN adds the prescale_i divider field.
//
// Signals:
//   cke_i       clock enable; low freezes all timer state
//   en_i        count enable; low freezes the count and the prescaler
//   load_i      single-cycle load strobe
//   load_val_i  duration to load (CNT_W bits)
//   periodic_i  1 = auto-reload on expiry, 0 = one-shot
//   irq_ack_i   single-cycle clear of the sticky interrupt
//   prescale_i  tick divider minus one (PSC_W bits, only with the macro)
//   count_o     remaining count
//   busy_o      high while counting (RUN)
//   expire_o    one-cycle expiry pulse
//   irq_o       sticky expiry flag
// -----------------------------------------------------------------------------
interface iob_timer_countdown_if #(
    parameter int unsigned CNT_W = 64,
    parameter int unsigned PSC_W = 16
);

    if (CNT_W < 2 || PSC_W < 1) begin : g_param_check
        $error("iob_timer_countdown_if: CNT_W must be >= 2 and PSC_W >= 1");
    end

    logic             cke_i;
    logic             en_i;
    logic             load_i;
    logic [CNT_W-1:0] load_val_i;
    logic             periodic_i;
    logic             irq_ack_i;
`ifdef IOB_TIMER_COUNTDOWN_PRESCALE_EN
    logic [PSC_W-1:0] prescale_i;
`endif
    logic [CNT_W-1:0] count_o;
    logic             busy_o;
    logic             expire_o;
    logic             irq_o;

    // CSR / driver side
    modport master (
        output cke_i,
        output en_i,
        output load_i,
        output load_val_i,
        output periodic_i,
        output irq_ack_i,
`ifdef IOB_TIMER_COUNTDOWN_PRESCALE_EN
        output prescale_i,
`endif
        input  count_o,
        input  busy_o,
        input  expire_o,
        input  irq_o
    );

    // Timer core side
    modport slave (
        input  cke_i,
        input  en_i,
        input  load_i,
        input  load_val_i,
        input  periodic_i,
        input  irq_ack_i,
`ifdef IOB_TIMER_COUNTDOWN_PRESCALE_EN
        input  prescale_i,
`endif
        output count_o,
        output busy_o,
        output expire_o,
        output irq_o
    );

endinterface

// File: rtl/iob_timer_countdown.sv
// -----------------------------------------------------------------------------
// iob_timer_countdown
//
// Purpose:
//   Down-counting alarm timer. The core is loaded with a duration and counts
//   it down one tick at a time. On expiry it raises a one-cycle event pulse and
//   a sticky interrupt. In one-shot mode it then stops at zero. In periodic
//   mode it reloads the last loaded duration and keeps counting.
//
// Optional feature:
//   IOB_TIMER_COUNTDOWN_PRESCALE_EN - when defined, a PSC_W-bit prescaler
//   divides enabled RUN cycles into ticks. One tick is issued every
//   (prescale_i+1) enabled cycles. When undefined, every enabled RUN cycle is
//   a tick.
//
// Ports:
//   clk_i     clock
//   arst_n_i  asynchronous active-low reset
//   bus       iob_timer_countdown_if.slave: the cke/en/load/periodic/ack
//             controls and the count/busy/expire/irq status
// -----------------------------------------------------------------------------
module iob_timer_countdown #(
    parameter int unsigned CNT_W = 64,
    parameter int unsigned PSC_W = 16
) (
    input  logic                        clk_i,
    input  logic                        arst_n_i,
    iob_timer_countdown_if.slave        bus
);

    if (CNT_W < 2 || PSC_W < 1) begin : g_param_check
        $error("iob_timer_countdown: CNT_W must be >= 2 and PSC_W >= 1");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_reload;
    logic             r_expire;
    logic             r_irq;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_reload_nxt;
    logic             w_expire_nxt;
    logic             w_irq_nxt;

    logic             w_run_en;   // counting cycle: RUN with en_i high
    logic             w_tick;     // one count step happens this cycle
    logic             w_last;     // the count reads one, so the next tick expires

`ifdef IOB_TIMER_COUNTDOWN_PRESCALE_EN
    logic [PSC_W-1:0] r_psc;
    logic [PSC_W-1:0] w_psc_nxt;
    logic             w_psc_hit;

    assign w_psc_hit = (r_psc == bus.prescale_i);
`endif

    assign w_run_en = (r_state == ST_RUN) && bus.en_i;
    assign w_last   = (r_count == CNT_W'(1));

`ifdef IOB_TIMER_COUNTDOWN_PRESCALE_EN
    assign w_tick = w_run_en && w_psc_hit;
`else
    assign w_tick = w_run_en;
`endif

    // -------------------------------------------------------------------------
    // Next-state / output logic
    //
    // Priority order: a load overrides any tick in the same cycle. This means a
    // load on the expiry cycle cancels the expiry, so no pulse is raised and
    // irq is not set. The acknowledge only clears irq. An expiry in the same
    // cycle sets it again, so a same-cycle ack cannot lose the event.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_expire_nxt = 1'b0;
        w_irq_nxt    = r_irq & ~bus.irq_ack_i;
`ifdef IOB_TIMER_COUNTDOWN_PRESCALE_EN
        w_psc_nxt    = r_psc;
`endif

        if (bus.load_i) begin
            w_count_nxt  = bus.load_val_i;
            w_reload_nxt = bus.load_val_i;
`ifdef IOB_TIMER_COUNTDOWN_PRESCALE_EN
            w_psc_nxt    = '0;
`endif
            // A zero duration stays idle and never expires.
            w_state_nxt  = (bus.load_val_i != '0) ? ST_RUN : ST_IDLE;
        end else if (w_tick) begin
`ifdef IOB_TIMER_COUNTDOWN_PRESCALE_EN
            w_psc_nxt = '0;
`endif
            if (w_last) begin
                // The expiry step replaces the decrement to zero. This keeps the
                // count from ever wrapping. periodic_i is sampled here only.
                w_expire_nxt = 1'b1;
                w_irq_nxt    = 1'b1;
                if (bus.periodic_i) begin
                    w_count_nxt = r_reload;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_count_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end else begin
                w_count_nxt = r_count - CNT_W'(1);
            end
        end
`ifdef IOB_TIMER_COUNTDOWN_PRESCALE_EN
        else if (w_run_en) begin
            w_psc_nxt = r_psc + PSC_W'(1);
        end
`endif
    end

    // -------------------------------------------------------------------------
    // State register. cke_i low freezes every register, including the expiry
    // pulse, so a held pulse resumes its single cycle once cke_i returns.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_expire <= 1'b0;
            r_irq    <= 1'b0;
        end else if (bus.cke_i) begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_expire <= w_expire_nxt;
            r_irq    <= w_irq_nxt;
        end
    end

`ifdef IOB_TIMER_COUNTDOWN_PRESCALE_EN
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_psc <= '0;
        end else if (bus.cke_i) begin
            r_psc <= w_psc_nxt;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.count_o  = r_count;
    assign bus.busy_o   = (r_state == ST_RUN);
    assign bus.expire_o = r_expire;
    assign bus.irq_o    = r_irq;

endmodule
